port_default_bank: RTL

//   Parametrised bank of NUM_CH registered port values, each with its own compile-time default.

---
 rtl/port_default_bank.sv | 129 ++++++++++++
 1 files changed

// File: rtl/port_default_bank.sv
// Bank of registered channel values, each with its own default.
// Handshaked writes, restore-to-default (parallel or sequential).
//
// Ports:
//   i_clk/i_rst_n        clock, async active-low reset
//   i_wr_valid/o_wr_ready write handshake
//   i_wr_ch/i_wr_data    write target and data
//   i_restore            restore all channels to defaults
//   o_busy               sequential restore running
//   o_value              registered channel values
//   o_changed            per-channel change pulse
//   o_err                rejected-write pulse
module port_default_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 8,
  parameter logic [NUM_CH*WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter logic [NUM_CH-1:0] TIE_MASK = '0,
  parameter bit SEQ_RESTORE = 1'b1,
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [IW-1:0]           i_wr_ch,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_restore,
  output logic                    o_busy,
  output logic [NUM_CH*WIDTH-1:0] o_value,
  output logic [NUM_CH-1:0]       o_changed,
  output logic                    o_err
);

  typedef enum logic {
    IDLE,
    RESTORE
  } state_t;

  state_t                    state_q;
  logic [IW-1:0]             idx_q;
  logic [NUM_CH*WIDTH-1:0]   val_q;
  logic [NUM_CH-1:0]         chg_q;
  logic                      err_q;

  logic              idle;
  logic              restore_go;
  logic              wr_fire;
  logic              wr_good;
  logic              wr_bad;
  logic              last;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] rs_sel;

  assign idle       = (state_q == IDLE);
  assign o_wr_ready = idle;
  assign o_busy     = (state_q == RESTORE);
  assign o_value    = val_q;
  assign o_changed  = chg_q;
  assign o_err      = err_q;

  assign restore_go = idle & i_restore;
  // Restore wins: a write in the same cycle is dropped silently.
  assign wr_fire    = idle & i_wr_valid & ~i_restore;
  assign last       = (32'(idx_q) == NUM_CH - 1);

  // Decoding by loop keeps out-of-range channels (ch>=NUM_CH)
  // from ever selecting anything, so they fall into wr_bad.
  always_comb begin
    wr_sel = '0;
    rs_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_sel[k] = (32'(i_wr_ch) == k);
      rs_sel[k] = (restore_go & ~SEQ_RESTORE)
                | (o_busy & (32'(idx_q) == k));
    end
  end

  assign wr_good = wr_fire & (|(wr_sel & ~TIE_MASK));
  assign wr_bad  = wr_fire & ~(|(wr_sel & ~TIE_MASK));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= DEFAULT_VALUE;
      chg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= wr_bad;
      for (int k = 0; k < NUM_CH; k++) begin
        if (TIE_MASK[k]) begin
          val_q[k*WIDTH +: WIDTH] <= DEFAULT_VALUE[k*WIDTH +: WIDTH];
          chg_q[k] <= 1'b0;
        end else if (rs_sel[k]) begin
          val_q[k*WIDTH +: WIDTH] <= DEFAULT_VALUE[k*WIDTH +: WIDTH];
          chg_q[k] <= (val_q[k*WIDTH +: WIDTH]
                       != DEFAULT_VALUE[k*WIDTH +: WIDTH]);
        end else if (wr_good && wr_sel[k]) begin
          val_q[k*WIDTH +: WIDTH] <= i_wr_data;
          chg_q[k] <= (val_q[k*WIDTH +: WIDTH] != i_wr_data);
        end else begin
          chg_q[k] <= 1'b0;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (restore_go && SEQ_RESTORE) begin
            state_q <= RESTORE;
            idx_q   <= '0;
          end
        end
        RESTORE: begin
          // No restart: i_restore is ignored until back in IDLE.
          if (last) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule
